// File: rtl/dcm_phase_seq_pkg.sv
// Shared opcodes, FSM states and error bit indices for the DCM phase sequencer.
package dcm_phase_seq_pkg;

  localparam logic [3:0] CMD_CLR   = 4'd0;
  localparam logic [3:0] CMD_INC   = 4'd1;
  localparam logic [3:0] CMD_DEC   = 4'd2;
  localparam logic [3:0] CMD_ZERO  = 4'd3;
  localparam logic [3:0] CMD_GOTO  = 4'd4;
  localparam logic [3:0] CMD_ABORT = 4'd5;
  localparam logic [3:0] CMD_NOP   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  localparam int ERR_BUSY  = 0;
  localparam int ERR_LIMIT = 1;
  localparam int ERR_TMO   = 2;

endpackage

// File: rtl/dcm_phase_wdog.sv
// PSDONE watchdog: counts enabled cycles, flags expiry on the (2^TMO_W-1)th one.
module dcm_phase_wdog #(
  parameter int TMO_W = 8
) (
  input  logic cclk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // count starts at 0 on the first enabled cycle
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dcm_phase_seq.sv
// Multi-channel DCM variable phase-shift sequencer, one channel moving at a time.
// Optional PSDONE watchdog enabled by DCM_PHASE_SEQ_TIMEOUT_EN.
module dcm_phase_seq
  import dcm_phase_seq_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PHASE_W   = 9,
  parameter int PHASE_MIN = -255,
  parameter int PHASE_MAX = 255,
  parameter int TMO_W     = 8,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic               wcmd,
  input  logic [CW-1:0]      wch,
  input  logic [3:0]         cmd,
  input  logic [PHASE_W-1:0] wdata,
  input  logic [CW-1:0]      rch,
  output logic [NCH-1:0]     ps_en,
  output logic [NCH-1:0]     ps_incdec,
  input  logic [NCH-1:0]     ps_done,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic [2:0]         err
);

  localparam int EW = PHASE_W + 1;
  localparam logic signed [EW-1:0] MAX_E = EW'(PHASE_MAX);
  localparam logic signed [EW-1:0] MIN_E = EW'(PHASE_MIN);

  state_e                    state_q, state_d;
  logic [CW-1:0]             ach_q, ach_d;
  logic signed [PHASE_W-1:0] tgt_q, tgt_d;
  logic signed [PHASE_W-1:0] phase_q [NCH];
  logic [NCH-1:0]            incdec_q;
  logic [2:0]                err_q, err_d, err_set;
  logic                      expire;

  logic                      is_move, is_abort, is_clr, lim;
  logic signed [PHASE_W-1:0] cur, tgt_new;
  logic signed [EW-1:0]      cur_e, raw, clamped;

  assign is_move  = wcmd && (cmd inside {CMD_INC, CMD_DEC, CMD_ZERO, CMD_GOTO});
  assign is_abort = wcmd && (cmd == CMD_ABORT);
  assign is_clr   = wcmd && (cmd == CMD_CLR);
  assign cur      = phase_q[wch];
  assign cur_e    = {cur[PHASE_W-1], cur};

  // target computed one bit wider so +1 at PHASE_MAX cannot wrap before clamping
  always_comb begin
    raw = cur_e;
    case (cmd)
      CMD_INC:  raw = cur_e + EW'(1);
      CMD_DEC:  raw = cur_e - EW'(1);
      CMD_ZERO: raw = '0;
      CMD_GOTO: raw = {wdata[PHASE_W-1], wdata};
      default:  raw = cur_e;
    endcase
    lim     = 1'b0;
    clamped = raw;
    if (raw > MAX_E) begin
      clamped = MAX_E;
      lim     = 1'b1;
    end else if (raw < MIN_E) begin
      clamped = MIN_E;
      lim     = 1'b1;
    end
    tgt_new = clamped[PHASE_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ach_d   = ach_q;
    tgt_d   = tgt_q;
    err_set = '0;
    case (state_q)
      ST_IDLE: if (is_move) begin
        ach_d              = wch;
        tgt_d              = tgt_new;
        err_set[ERR_LIMIT] = lim;
        if (tgt_new != cur) state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ps_done[ach_q]) state_d = ST_CHECK;
        else if (expire) begin
          state_d          = ST_IDLE;
          err_set[ERR_TMO] = 1'b1;
        end
      end
      ST_CHECK: state_d = (phase_q[ach_q] == tgt_q) ? ST_IDLE : ST_STEP;
      default:  state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && is_move) err_set[ERR_BUSY] = 1'b1;
    if (is_abort) state_d = ST_IDLE;
    err_d = (is_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ach_q    <= '0;
      tgt_q    <= '0;
      incdec_q <= '0;
      err_q    <= '0;
      for (int i = 0; i < NCH; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ach_q   <= ach_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      // direction must be stable during the STEP cycle, so latch it on entry
      if (state_d == ST_STEP) incdec_q[ach_d] <= (tgt_d > phase_q[ach_d]);
      if (state_q == ST_WAIT && ps_done[ach_q] && !is_abort)
        phase_q[ach_q] <= (tgt_q > phase_q[ach_q]) ? phase_q[ach_q] + 1'b1
                                                   : phase_q[ach_q] - 1'b1;
    end
  end

`ifdef DCM_PHASE_SEQ_TIMEOUT_EN
  dcm_phase_wdog #(.TMO_W(TMO_W)) u_wdog (
    .cclk     (cclk),
    .rst      (rst),
    .clr_i    (state_q == ST_STEP),
    .en_i     (state_q == ST_WAIT),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    ps_en = '0;
    if (state_q == ST_STEP && !is_abort) ps_en[ach_q] = 1'b1;
  end

  assign ps_incdec = incdec_q;
  assign phase     = phase_q[rch];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_IDLE);
  // bit 2 can only be set by the watchdog, so it reads 0 when that is absent
  assign err       = err_q;

endmodule
